// File: rtl/axis_requantizer.sv
// Requantizes 16 unsigned 16-bit weighted samples per beat to 8 bits (shift, round-half-up, saturate)
// through a two-stage elastic AXI-Stream pipeline, counting beats that saturated any kept lane.
module axis_requantizer #(
    parameter int SDATA_WIDTH   = 256,
    parameter int SSAMPLE_WIDTH = 16,
    parameter int MSAMPLE_WIDTH = 8,
    parameter int MDATA_WIDTH   = 128,
    parameter int SHIFT_WIDTH   = 4,
    parameter int CNT_WIDTH     = 32
) (
    input  logic                          CLK,
    input  logic                          resetn,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    input  logic [SDATA_WIDTH-1:0]        s_axis_tdata,
    input  logic [SDATA_WIDTH/SSAMPLE_WIDTH-1:0] s_axis_tkeep,
    input  logic                          s_axis_tlast,
    input  logic [SHIFT_WIDTH-1:0]        shift,
    input  logic                          sat_clear,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic [MDATA_WIDTH-1:0]        m_axis_tdata,
    output logic [SDATA_WIDTH/SSAMPLE_WIDTH-1:0] m_axis_tkeep,
    output logic                          m_axis_tlast,
    output logic [CNT_WIDTH-1:0]          sat_count
);

    localparam int SAMPLES = SDATA_WIDTH / SSAMPLE_WIDTH;
    localparam int RWIDTH  = SSAMPLE_WIDTH + 1;
    localparam logic [RWIDTH-1:0] MAX_OUT = RWIDTH'((1 << MSAMPLE_WIDTH) - 1);

    logic                   p1_v;
    logic [MDATA_WIDTH-1:0] p1_data;
    logic [SAMPLES-1:0]     p1_keep;
    logic                   p1_last;

    logic [MDATA_WIDTH-1:0] q_data;
    logic [SAMPLES-1:0]     sat_lane;
    logic [RWIDTH-1:0]      half;
    logic                   o_adv;
    logic                   p1_load;

    // One extra bit of headroom keeps x + half from wrapping before the shift
    assign half = (shift == '0) ? '0 : (RWIDTH'(1) << (shift - SHIFT_WIDTH'(1)));

    genvar i;
    generate
        for (i = 0; i < SAMPLES; i++) begin : g_lane
            logic [RWIDTH-1:0] rounded;
            logic              over;
            assign rounded     = ({1'b0, s_axis_tdata[i*SSAMPLE_WIDTH +: SSAMPLE_WIDTH]} + half) >> shift;
            assign over        = rounded > MAX_OUT;
            assign sat_lane[i] = over && s_axis_tkeep[i];
            assign q_data[i*MSAMPLE_WIDTH +: MSAMPLE_WIDTH] =
                !s_axis_tkeep[i] ? '0 :
                over             ? '1 : rounded[MSAMPLE_WIDTH-1:0];
        end
    endgenerate

    assign o_adv         = !m_axis_tvalid || m_axis_tready;
    assign s_axis_tready = resetn && (!p1_v || o_adv);
    assign p1_load       = s_axis_tvalid && s_axis_tready;

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            p1_v    <= 1'b0;
            p1_data <= '0;
            p1_keep <= '0;
            p1_last <= 1'b0;
        end else if (p1_load) begin
            p1_v    <= 1'b1;
            p1_data <= q_data;
            p1_keep <= s_axis_tkeep;
            p1_last <= s_axis_tlast;
        end else if (o_adv) begin
            p1_v    <= 1'b0;
        end
    end

    // Output registers only change on advance, so a stalled beat stays stable
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
        end else if (o_adv) begin
            m_axis_tvalid <= p1_v;
            if (p1_v) begin
                m_axis_tdata <= p1_data;
                m_axis_tkeep <= p1_keep;
                m_axis_tlast <= p1_last;
            end
        end
    end

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            sat_count <= '0;
        end else if (sat_clear) begin
            sat_count <= '0;
        end else if (p1_load && (|sat_lane) && !(&sat_count)) begin
            sat_count <= sat_count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_axis_requantizer.sv
// Self-checking bench for axis_requantizer: randomized beats scored against an arithmetic model;
// a 3-bit counter instance shares the stimulus to exercise counter saturation.
module tb_axis_requantizer;

    logic         CLK = 1'b0;
    logic         resetn;
    logic         s_axis_tvalid;
    logic         s_axis_tready, s_tready_small;
    logic [255:0] s_axis_tdata;
    logic [15:0]  s_axis_tkeep;
    logic         s_axis_tlast;
    logic [3:0]   shift;
    logic         sat_clear;
    logic         m_axis_tvalid, m_tvalid_small;
    logic         m_axis_tready;
    logic [127:0] m_axis_tdata, m_tdata_small;
    logic [15:0]  m_axis_tkeep, m_tkeep_small;
    logic         m_axis_tlast, m_tlast_small;
    logic [31:0]  sat_count;
    logic [2:0]   sat_small;

    typedef struct packed { logic [127:0] d; logic [15:0] k; logic l; } beat_t;

    beat_t  exp_q[$];
    beat_t  got_q[$];
    longint model_sat;
    int     model_small;
    int     stable_err;
    beat_t  held;
    bit     held_v;
    int     n_checks;
    int     n_fail;

    always #5 CLK = ~CLK;

    axis_requantizer dut (
        .CLK(CLK), .resetn(resetn),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tlast(s_axis_tlast),
        .shift(shift), .sat_clear(sat_clear),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
        .sat_count(sat_count)
    );

    axis_requantizer #(.CNT_WIDTH(3)) dut_small (
        .CLK(CLK), .resetn(resetn),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_tready_small),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tlast(s_axis_tlast),
        .shift(shift), .sat_clear(sat_clear),
        .m_axis_tvalid(m_tvalid_small), .m_axis_tready(m_axis_tready),
        .m_axis_tdata(m_tdata_small), .m_axis_tkeep(m_tkeep_small), .m_axis_tlast(m_tlast_small),
        .sat_count(sat_small)
    );

    // Requantization expressed as integer arithmetic on each 16-bit lane
    function automatic beat_t model_beat(input logic [255:0] d, input logic [15:0] k,
                                         input logic l, input int sh, output bit sat);
        beat_t b;
        int x, r;
        b.d = '0; b.k = k; b.l = l; sat = 0;
        for (int i = 0; i < 16; i++) begin
            x = int'(d[16*i +: 16]);
            r = (sh == 0) ? x : (x + (1 << (sh - 1))) / (1 << sh);
            if (k[i]) begin
                if (r > 255) begin
                    b.d[8*i +: 8] = 8'hFF;
                    sat = 1;
                end else begin
                    b.d[8*i +: 8] = r[7:0];
                end
            end
        end
        return b;
    endfunction

    // Observes handshakes at the falling edge; they complete on the following rising edge
    always @(negedge CLK) begin
        beat_t cur, e;
        bit    s;
        cur = '{d: m_axis_tdata, k: m_axis_tkeep, l: m_axis_tlast};
        if (!resetn) begin
            held_v = 0;
        end else begin
            if (held_v && (!m_axis_tvalid || cur !== held)) stable_err++;
            held_v = m_axis_tvalid && !m_axis_tready;
            held   = cur;
            if (s_axis_tvalid && s_axis_tready) begin
                e = model_beat(s_axis_tdata, s_axis_tkeep, s_axis_tlast, int'(shift), s);
                exp_q.push_back(e);
            end else begin
                s = 0;
            end
            if (sat_clear) begin
                model_sat   = 0;
                model_small = 0;
            end else if (s) begin
                if (model_sat < 64'hFFFF_FFFF) model_sat++;
                if (model_small < 7) model_small++;
            end
            if (m_axis_tvalid && m_axis_tready) got_q.push_back(cur);
        end
    end

    task automatic send(input logic [255:0] d, input logic [15:0] k, input logic l,
                        input bit rnd, output bit ok);
        int n = 0;
        bit hs;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tlast  = l;
        do begin
            if (rnd) m_axis_tready = 1'($urandom_range(0, 1));
            @(negedge CLK);
            hs = s_axis_tready;
            @(posedge CLK);
            #1;
            n++;
        end while (!hs && n < 200);
        ok = hs;
        s_axis_tvalid = 1'b0;
    endtask

    task automatic drain(input bit rnd, output bit ok);
        int n = 0;
        s_axis_tvalid = 1'b0;
        while (got_q.size() < exp_q.size() && n < 500) begin
            m_axis_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge CLK);
            #1;
            n++;
        end
        m_axis_tready = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        ok = (got_q.size() == exp_q.size());
    endtask

    task automatic test_reset();
        resetn = 1'b1; s_axis_tvalid = 1'b1; s_axis_tdata = '1; s_axis_tkeep = '1;
        s_axis_tlast = 1'b0; shift = '0; sat_clear = 1'b0; m_axis_tready = 1'b1;
        model_sat = 0; model_small = 0; stable_err = 0; held_v = 0;
        #2 resetn = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        n_checks++;
        if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_tvalid got %b want 0", m_axis_tvalid); end
        n_checks++;
        if (m_axis_tdata !== '0) begin n_fail++; $display("[TB] FAIL reset_tdata got %h want 0", m_axis_tdata); end
        n_checks++;
        if (sat_count !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_sat got %0d want 0", sat_count); end
        n_checks++;
        if (s_axis_tready !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_tready got %b want 0", s_axis_tready); end
        s_axis_tvalid = 1'b0;
        resetn = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_round();
        logic [255:0] d;
        bit ok;
        beat_t e, g;
        d = '0;
        d[15:0] = 16'h1280;
        shift = 4'd8;
        send(d, 16'hFFFF, 1'b1, 0, ok);
        n_checks++;
        if (!ok || m_axis_tvalid !== 1'b0) begin n_fail++; $display("[TB] FAIL round_early got accepted=%0d tvalid=%b want 1/0", ok, m_axis_tvalid); end
        @(posedge CLK);
        #1;
        n_checks++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata[7:0] !== 8'h13) begin
            n_fail++; $display("[TB] FAIL round_lane0 got valid=%b lane0=%h want 1/13", m_axis_tvalid, m_axis_tdata[7:0]);
        end
        drain(0, ok);
        n_checks++;
        if (!ok || exp_q.size() != 1) begin n_fail++; $display("[TB] FAIL round_count got %0d want 1", got_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            n_checks++;
            if (g !== e) begin n_fail++; $display("[TB] FAIL round_beat got %h want %h", g, e); end
        end
        n_checks++;
        if (sat_count !== 32'd0) begin n_fail++; $display("[TB] FAIL round_sat got %0d want 0", sat_count); end
    endtask

    task automatic test_saturate();
        logic [255:0] d;
        bit ok;
        beat_t e, g;
        for (int i = 0; i < 16; i++) d[16*i +: 16] = 16'h00FF;
        d[16*5 +: 16] = 16'h0100;
        shift = 4'd0;
        send(d, 16'hFFFF, 1'b0, 0, ok);
        drain(0, ok);
        n_checks++;
        if (!ok || got_q.size() != 1 || got_q[0].d !== {16{8'hFF}}) begin
            n_fail++; $display("[TB] FAIL sat_lanes got %h want all FF", got_q.size() > 0 ? got_q[0].d : '0);
        end
        n_checks++;
        if (sat_count !== 32'd1) begin n_fail++; $display("[TB] FAIL sat_count1 got %0d want 1", sat_count); end
        send(d, 16'hFFDF, 1'b1, 0, ok);
        drain(0, ok);
        n_checks++;
        if (!ok || got_q.size() != 2 || got_q[1].d[47:40] !== 8'h00) begin
            n_fail++; $display("[TB] FAIL sat_keep0 got %h want lane5 00", got_q.size() > 1 ? got_q[1].d : '0);
        end
        n_checks++;
        if (sat_count !== 32'd1) begin n_fail++; $display("[TB] FAIL sat_count_hold got %0d want 1", sat_count); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            n_checks++;
            if (g !== e) begin n_fail++; $display("[TB] FAIL sat_beat got %h want %h", g, e); end
        end
    endtask

    task automatic test_random();
        logic [255:0] d;
        bit ok;
        int sends_bad = 0;
        beat_t e, g;
        for (int n = 0; n < 100; n++) begin
            for (int w = 0; w < 8; w++) d[32*w +: 32] = $urandom;
            shift = 4'($urandom_range(0, 15));
            send(d, 16'($urandom), 1'($urandom_range(0, 1)), 1, ok);
            if (!ok) sends_bad++;
        end
        drain(1, ok);
        n_checks++;
        if (!ok || sends_bad != 0 || exp_q.size() != 100) begin
            n_fail++; $display("[TB] FAIL rand_count got %0d beats, %0d stuck sends, want 100/0", got_q.size(), sends_bad);
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            n_checks++;
            if (g !== e) begin n_fail++; $display("[TB] FAIL rand_beat got %h want %h", g, e); end
        end
        n_checks++;
        if (stable_err != 0) begin n_fail++; $display("[TB] FAIL rand_stable got %0d changes want 0", stable_err); end
        n_checks++;
        if (sat_count !== model_sat[31:0]) begin n_fail++; $display("[TB] FAIL rand_sat got %0d want %0d", sat_count, model_sat); end
    endtask

    task automatic test_back_to_back();
        int acc = 0;
        bit hs, ok;
        beat_t e, g;
        m_axis_tready = 1'b0;
        shift = 4'd3;
        s_axis_tvalid = 1'b1;
        s_axis_tkeep = 16'hFFFF;
        for (int w = 0; w < 8; w++) s_axis_tdata[32*w +: 32] = $urandom;
        s_axis_tlast = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge CLK);
            hs = s_axis_tready;
            @(posedge CLK);
            #1;
            if (hs) begin
                acc++;
                for (int w = 0; w < 8; w++) s_axis_tdata[32*w +: 32] = $urandom;
                s_axis_tlast = (acc == 1);
            end
        end
        n_checks++;
        if (acc != 2) begin n_fail++; $display("[TB] FAIL bp_absorbed got %0d want 2", acc); end
        n_checks++;
        if (s_axis_tready !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_tready got %b want 0", s_axis_tready); end
        drain(0, ok);
        n_checks++;
        if (!ok || exp_q.size() != 2 || got_q[1].l !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_drain got %0d beats want 2 ending in tlast", got_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            n_checks++;
            if (g !== e) begin n_fail++; $display("[TB] FAIL bp_beat got %h want %h", g, e); end
        end
        n_checks++;
        if (stable_err != 0) begin n_fail++; $display("[TB] FAIL bp_stable got %0d changes want 0", stable_err); end
    endtask

    task automatic test_sat_hold();
        bit ok;
        shift = 4'd0;
        for (int n = 0; n < 10; n++) send('1, 16'hFFFF, 1'b0, 0, ok);
        drain(0, ok);
        n_checks++;
        if (sat_small !== 3'd7) begin n_fail++; $display("[TB] FAIL hold_small got %0d want 7", sat_small); end
        n_checks++;
        if (sat_count !== model_sat[31:0]) begin n_fail++; $display("[TB] FAIL hold_main got %0d want %0d", sat_count, model_sat); end
        sat_clear = 1'b1;
        send('1, 16'hFFFF, 1'b1, 0, ok);
        sat_clear = 1'b0;
        drain(0, ok);
        n_checks++;
        if (sat_small !== 3'd0 || sat_count !== 32'd0) begin
            n_fail++; $display("[TB] FAIL clear_wins got %0d/%0d want 0/0", sat_small, sat_count);
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_reset_mid();
        bit ok;
        int seen = 0;
        m_axis_tready = 1'b0;
        shift = 4'd0;
        send('1, 16'hFFFF, 1'b0, 0, ok);
        send('1, 16'hFFFF, 1'b1, 0, ok);
        @(negedge CLK);
        #2 resetn = 1'b0;
        #1;
        n_checks++;
        if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== '0 || m_axis_tkeep !== '0 || m_axis_tlast !== 1'b0) begin
            n_fail++; $display("[TB] FAIL midreset_out got v=%b k=%h l=%b want 0", m_axis_tvalid, m_axis_tkeep, m_axis_tlast);
        end
        n_checks++;
        if (s_axis_tready !== 1'b0 || sat_count !== 32'd0) begin
            n_fail++; $display("[TB] FAIL midreset_in got tready=%b sat=%0d want 0/0", s_axis_tready, sat_count);
        end
        exp_q.delete();
        got_q.delete();
        model_sat = 0;
        model_small = 0;
        @(posedge CLK);
        #1 resetn = 1'b1;
        m_axis_tready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge CLK);
            #1;
            if (m_axis_tvalid) seen++;
        end
        n_checks++;
        if (seen != 0 || got_q.size() != 0) begin n_fail++; $display("[TB] FAIL midreset_stale got %0d beats want 0", seen); end
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        test_reset();
        test_round();
        test_saturate();
        test_random();
        test_back_to_back();
        test_sat_hold();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
